alu_div: RTL and testbench

ALU_DIV -- requirements
Module: alu_div

---
 rtl/alu_div.sv | 126 ++++++++++++
 tb/tb_alu_div.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_div.sv
// Signed restoring divider: one quotient bit per clock on magnitudes, with the
// signs applied when the result is registered.
module alu_div #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid,
    input  logic signed [WIDTH-1:0] dividendo,
    input  logic signed [WIDTH-1:0] divisor,
    output logic                    ready,
    output logic                    done,
    output logic signed [WIDTH-1:0] cociente,
    output logic signed [WIDTH-1:0] residuo,
    output logic                    div_cero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

    state_t state, state_next;

    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] dvd_raw;
    logic             sign_dvd;
    logic             sign_dvs;
    logic             zero_div;

    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic             step_neg;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quot_step;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (valid) state_next = DIVIDE;
            end
            DIVIDE: begin
                if (count == LAST) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Magnitudes are unsigned, so the most negative operand maps to 2^(WIDTH-1).
    always_comb begin
        dvd_abs   = dividendo[WIDTH-1] ? WIDTH'(-dividendo) : WIDTH'(dividendo);
        dvs_abs   = divisor[WIDTH-1]   ? WIDTH'(-divisor)   : WIDTH'(divisor);
        rem_sh    = {rem[WIDTH-1:0], quot[WIDTH-1]};
        trial     = {1'b0, rem_sh} - {2'b00, dvs_mag};
        step_neg  = trial[WIDTH+1];
        rem_step  = step_neg ? rem_sh : trial[WIDTH:0];
        quot_step = {quot[WIDTH-2:0], ~step_neg};
        q_res     = (sign_dvd ^ sign_dvs) ? WIDTH'(-quot_step) : quot_step;
        r_res     = sign_dvd ? WIDTH'(-rem_step[WIDTH-1:0]) : rem_step[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // A zero divisor spends a single DIVIDE cycle (counter preloaded to its last
    // value) so its result appears one cycle after acceptance, not eight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            rem      <= '0;
            quot     <= '0;
            dvs_mag  <= '0;
            dvd_raw  <= '0;
            sign_dvd <= 1'b0;
            sign_dvs <= 1'b0;
            zero_div <= 1'b0;
            cociente <= '0;
            residuo  <= '0;
            div_cero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        quot     <= dvd_abs;
                        dvs_mag  <= dvs_abs;
                        dvd_raw  <= dividendo;
                        sign_dvd <= dividendo[WIDTH-1];
                        sign_dvs <= divisor[WIDTH-1];
                        rem      <= '0;
                        zero_div <= (divisor == '0);
                        count    <= (divisor == '0) ? LAST : '0;
                    end
                end
                DIVIDE: begin
                    rem   <= rem_step;
                    quot  <= quot_step;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        cociente <= zero_div ? '1 : q_res;
                        residuo  <= zero_div ? dvd_raw : r_res;
                        div_cero <= zero_div;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div.sv
// Randomised scoreboard bench for alu_div: a driver queues expected results from
// an integer-arithmetic model, a monitor checks them whenever done pulses.
module tb_alu_div;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              valid = 1'b0;
    logic signed [7:0] dividendo = '0;
    logic signed [7:0] divisor = '0;
    logic              ready;
    logic              done;
    logic signed [7:0] cociente;
    logic signed [7:0] residuo;
    logic              div_cero;

    typedef struct {
        logic signed [7:0] q;
        logic signed [7:0] r;
        logic              dz;
        int                acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    int   prev_acc = -1;
    bit   prev_held = 0;
    bit   prev_zero = 0;

    alu_div #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .valid(valid),
        .dividendo(dividendo), .divisor(divisor),
        .ready(ready), .done(done),
        .cociente(cociente), .residuo(residuo), .div_cero(div_cero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Truncating integer division already has the required sign rules.
    function automatic exp_t model(input logic signed [7:0] a, input logic signed [7:0] b);
        exp_t e;
        int ai = a;
        int bi = b;
        e.acc = 0;
        if (bi == 0) begin
            e.q  = 8'shFF;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = 8'(ai / bi);
            e.r  = 8'(ai % bi);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic signed [7:0] a, input logic signed [7:0] b, input bit hold);
        exp_t e;
        int   waits = 0;
        @(negedge clk);
        valid     = 1'b1;
        dividendo = a;
        divisor   = b;
        while (!ready && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (!ready) begin
            checkOutput("ready_timeout", 0, 1);
            valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e     = model(a, b);
        e.acc = edge_cnt;
        if (prev_held && prev_acc >= 0)
            checkOutput("b2b_period", e.acc - prev_acc, prev_zero ? 3 : 10);
        sb.push_back(e);
        prev_acc  = e.acc;
        prev_held = hold;
        prev_zero = (b == 0);
        if (!hold) begin
            @(negedge clk);
            valid = 1'b0;
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", sb.size(), 0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("cociente", cociente, e.q);
                    checkOutput("residuo", residuo, e.r);
                    checkOutput("div_cero", div_cero, e.dz);
                    checkOutput("latency", edge_cnt - e.acc, e.dz ? 1 : 8);
                end
            end
        end
    end

    initial begin
        #3;
        checkOutput("rst_ready", ready, 1);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_cociente", cociente, 0);
        checkOutput("rst_residuo", residuo, 0);
        checkOutput("rst_div_cero", div_cero, 0);
        #14 rst = 1'b1;

        applyStimulus(8'sd100, 8'sd7, 0);
        applyStimulus(-8'sd100, 8'sd7, 0);
        applyStimulus(8'sd100, -8'sd7, 0);
        applyStimulus(-8'sd100, -8'sd7, 0);
        applyStimulus(8'sd5, 8'sd0, 0);
        applyStimulus(8'sd9, 8'sd3, 0);
        applyStimulus(-8'sd128, -8'sd1, 0);
        applyStimulus(-8'sd128, 8'sd1, 0);
        applyStimulus(8'sd127, -8'sd128, 0);
        applyStimulus(8'sd100, 8'sd7, 1);
        applyStimulus(8'sd50, 8'sd5, 0);
        waitDrain();

        applyStimulus(8'sd100, 8'sd7, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        sb.delete();
        prev_held = 0;
        checkOutput("abort_ready", ready, 1);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_cociente", cociente, 0);
        checkOutput("abort_residuo", residuo, 0);
        checkOutput("abort_div_cero", div_cero, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("post_abort_ready", ready, 1);
        applyStimulus(8'sd20, 8'sd6, 0);
        waitDrain();

        for (int i = 0; i < 150; i++) begin
            logic signed [7:0] a;
            logic signed [7:0] b;
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'sd0 : 8'($urandom);
            if ($urandom_range(0, 9) == 0) a = -8'sd128;
            if ($urandom_range(0, 9) == 0) b = ($urandom_range(0, 1) == 1) ? -8'sd1 : -8'sd128;
            applyStimulus(a, b, bit'($urandom_range(0, 1)));
        end
        @(negedge clk);
        valid = 1'b0;
        waitDrain();
        repeat (15) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
